// File: rtl/core_lsu_wport.sv
// Dcache write port and refill engine: write-through store buffer, line refill, uncached read, invalidate.
// Optional DCACHE_REFILL_EARLY_READY_EN returns the critical word during the burst instead of at tag write.
module core_lsu_wport #(
    parameter int WAY_CNT    = 2,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   refill_req_i,
    input  logic                   uc_read_req_i,
    input  logic                   hit_write_i,
    input  logic                   miss_write_i,
    input  logic                   uc_write_i,
    input  logic                   inv_req_i,
    input  logic [31:0]            addr_i,
    input  logic [1:0]             size_i,
    input  logic [WAY_CNT-1:0]     wsel_i,
    input  logic [3:0]             wstrb_i,
    input  logic [31:0]            wdata_i,
    output logic                   read_ready_o,
    output logic [31:0]            rdata_o,
    output logic                   uop_ready_o,
    output logic                   uc_write_ready_o,
    output logic                   wbuf_full_o,
    output logic [9:0]             data_waddr_o,
    output logic [WAY_CNT*4-1:0]   data_we_o,
    output logic [31:0]            data_wdata_o,
    output logic [7:0]             tag_waddr_o,
    output logic [WAY_CNT-1:0]     tag_we_o,
    output logic [20:0]            tag_wdata_o,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [31:0]            bus_addr_o,
    output logic [1:0]             bus_size_o,
    output logic [1:0]             bus_len_o,
    output logic [31:0]            bus_wdata_o,
    output logic [3:0]             bus_wstrb_o,
    input  logic                   bus_ready_i,
    input  logic                   bus_rvalid_i,
    input  logic [31:0]            bus_rdata_i,
    input  logic                   bus_rlast_i
);

    localparam int VW = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam int AW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE, DRAIN, RD_REQ, RD_DATA, TAG_WR, UC_REQ, UC_DATA, INV
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } wbuf_entry_t;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [VW-1:0]     victim_q, victim_d;
    logic [1:0]        beat_q, beat_d;
`ifndef DCACHE_REFILL_EARLY_READY_EN
    logic [31:0]       rdata_q, rdata_d;
`endif

    wbuf_entry_t       wbuf_q [WBUF_DEPTH];
    wbuf_entry_t       enq_entry;
    wbuf_entry_t       head;
    logic              full, empty, enq, deq, wr_phase;

    assign full      = (count_q == CW'(WBUF_DEPTH));
    assign empty     = (count_q == '0);
    assign wr_phase  = (state_q == IDLE) || (state_q == DRAIN);
    assign head      = wbuf_q[rd_ptr_q];
    assign enq_entry = '{addr: addr_i, size: size_i, strb: wstrb_i, wdata: wdata_i};
    // Stores enqueue whatever the FSM is doing; the full check also guards against an illegal hit store.
    assign enq       = rst_n && (hit_write_i || miss_write_i || uc_write_i) && !full;
    assign deq       = wr_phase && !empty && bus_ready_i;

    assign uc_write_ready_o = !full;
    assign wbuf_full_o      = full;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq && !deq) count_d = count_q + CW'(1);
        else if (deq && !enq) count_d = count_q - CW'(1);
        if (enq) wr_ptr_d = (wr_ptr_q == AW'(WBUF_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (deq) rd_ptr_d = (rd_ptr_q == AW'(WBUF_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        beat_d   = beat_q;
`ifndef DCACHE_REFILL_EARLY_READY_EN
        rdata_d  = rdata_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (inv_req_i) state_d = INV;
                else if (refill_req_i || uc_read_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (empty) begin
                    if (refill_req_i) state_d = RD_REQ;
                    else if (uc_read_req_i) state_d = UC_REQ;
                    else state_d = IDLE;
                end
            end
            RD_REQ: begin
                beat_d = '0;
                if (bus_ready_i) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (bus_rvalid_i) begin
                    beat_d = beat_q + 2'd1;
`ifndef DCACHE_REFILL_EARLY_READY_EN
                    if (beat_q == addr_i[3:2]) rdata_d = bus_rdata_i;
`endif
                    if (bus_rlast_i) state_d = TAG_WR;
                end
            end
            TAG_WR: begin
                victim_d = (victim_q == VW'(WAY_CNT - 1)) ? '0 : victim_q + VW'(1);
                state_d  = IDLE;
            end
            UC_REQ: if (bus_ready_i) state_d = UC_DATA;
            UC_DATA: if (bus_rvalid_i) state_d = IDLE;
            INV: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            victim_q <= '0;
            beat_q   <= '0;
`ifndef DCACHE_REFILL_EARLY_READY_EN
            rdata_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            victim_q <= victim_d;
            beat_q   <= beat_d;
`ifndef DCACHE_REFILL_EARLY_READY_EN
            rdata_q  <= rdata_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (enq) wbuf_q[wr_ptr_q] <= enq_entry;
    end

    // Refill beats own the data RAM port; the pipeline is stalled during refill so hit stores do not collide.
    always_comb begin
        data_waddr_o = '0;
        data_we_o    = '0;
        data_wdata_o = '0;
        if (state_q == RD_DATA && bus_rvalid_i) begin
            data_waddr_o = {addr_i[11:4], beat_q};
            data_wdata_o = bus_rdata_i;
            for (int unsigned w = 0; w < WAY_CNT; w++) begin
                if (victim_q == VW'(w)) data_we_o[w*4 +: 4] = 4'hF;
            end
        end else if (rst_n && hit_write_i) begin
            data_waddr_o = addr_i[11:2];
            data_wdata_o = wdata_i;
            for (int unsigned w = 0; w < WAY_CNT; w++) begin
                if (wsel_i[w]) data_we_o[w*4 +: 4] = wstrb_i;
            end
        end
    end

    always_comb begin
        tag_waddr_o = '0;
        tag_we_o    = '0;
        tag_wdata_o = '0;
        if (state_q == INV) begin
            tag_waddr_o = addr_i[11:4];
            tag_we_o    = '1;
        end else if (state_q == TAG_WR) begin
            tag_waddr_o = addr_i[11:4];
            tag_wdata_o = {1'b1, addr_i[31:12]};
            for (int unsigned w = 0; w < WAY_CNT; w++) begin
                if (victim_q == VW'(w)) tag_we_o[w] = 1'b1;
            end
        end
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_size_o  = '0;
        bus_len_o   = '0;
        bus_wdata_o = '0;
        bus_wstrb_o = '0;
        if (wr_phase && !empty) begin
            bus_req_o   = 1'b1;
            bus_we_o    = 1'b1;
            bus_addr_o  = head.addr;
            bus_size_o  = head.size;
            bus_wdata_o = head.wdata;
            bus_wstrb_o = head.strb;
        end else if (state_q == RD_REQ) begin
            bus_req_o  = 1'b1;
            bus_addr_o = {addr_i[31:4], 4'b0};
            bus_size_o = 2'd2;
            bus_len_o  = 2'd3;
        end else if (state_q == UC_REQ) begin
            bus_req_o  = 1'b1;
            bus_addr_o = addr_i;
            bus_size_o = size_i;
        end
    end

    always_comb begin
        read_ready_o = 1'b0;
        rdata_o      = '0;
        uop_ready_o  = (rst_n && miss_write_i && !full) || (state_q == TAG_WR) || (state_q == INV);
        if (state_q == UC_DATA && bus_rvalid_i) begin
            read_ready_o = 1'b1;
            rdata_o      = bus_rdata_i;
        end
`ifdef DCACHE_REFILL_EARLY_READY_EN
        if (state_q == RD_DATA && bus_rvalid_i && beat_q == addr_i[3:2]) begin
            read_ready_o = 1'b1;
            rdata_o      = bus_rdata_i;
        end
`else
        if (state_q == TAG_WR) begin
            read_ready_o = 1'b1;
            rdata_o      = rdata_q;
        end
`endif
    end

endmodule

// File: tb/tb_core_lsu_wport.sv
// Directed self-checking bench for core_lsu_wport (default build, 2 ways, 4-entry write buffer).
module tb_core_lsu_wport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refill_req_i, uc_read_req_i, hit_write_i, miss_write_i, uc_write_i, inv_req_i;
    logic [31:0] addr_i;
    logic [1:0]  size_i;
    logic [1:0]  wsel_i;
    logic [3:0]  wstrb_i;
    logic [31:0] wdata_i;
    logic        read_ready_o;
    logic [31:0] rdata_o;
    logic        uop_ready_o, uc_write_ready_o, wbuf_full_o;
    logic [9:0]  data_waddr_o;
    logic [7:0]  data_we_o;
    logic [31:0] data_wdata_o;
    logic [7:0]  tag_waddr_o;
    logic [1:0]  tag_we_o;
    logic [20:0] tag_wdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [1:0]  bus_size_o, bus_len_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_ready_i, bus_rvalid_i, bus_rlast_i;
    logic [31:0] bus_rdata_i;

    int total = 0;
    int passes = 0;
    int fails = 0;

    core_lsu_wport #(.WAY_CNT(2), .WBUF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .refill_req_i(refill_req_i), .uc_read_req_i(uc_read_req_i), .hit_write_i(hit_write_i),
        .miss_write_i(miss_write_i), .uc_write_i(uc_write_i), .inv_req_i(inv_req_i),
        .addr_i(addr_i), .size_i(size_i), .wsel_i(wsel_i), .wstrb_i(wstrb_i), .wdata_i(wdata_i),
        .read_ready_o(read_ready_o), .rdata_o(rdata_o), .uop_ready_o(uop_ready_o),
        .uc_write_ready_o(uc_write_ready_o), .wbuf_full_o(wbuf_full_o),
        .data_waddr_o(data_waddr_o), .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
        .tag_waddr_o(tag_waddr_o), .tag_we_o(tag_we_o), .tag_wdata_o(tag_wdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_size_o(bus_size_o), .bus_len_o(bus_len_o), .bus_wdata_o(bus_wdata_o),
        .bus_wstrb_o(bus_wstrb_o), .bus_ready_i(bus_ready_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_rlast_i(bus_rlast_i)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] beat_a [4];
    logic [31:0] drain_addr [4];

    initial begin
        beat_a[0] = 32'hA000_0000; beat_a[1] = 32'hA111_1111;
        beat_a[2] = 32'hA222_2222; beat_a[3] = 32'hA333_3333;
        drain_addr[0] = 32'h108; drain_addr[1] = 32'h10C;
        drain_addr[2] = 32'h400; drain_addr[3] = 32'h404;

        rst_n = 1'b0;
        refill_req_i = 0; uc_read_req_i = 0; hit_write_i = 0; miss_write_i = 0;
        uc_write_i = 0; inv_req_i = 0; addr_i = '0; size_i = 2'd2; wsel_i = '0;
        wstrb_i = '0; wdata_i = '0; bus_ready_i = 0; bus_rvalid_i = 0; bus_rlast_i = 0;
        bus_rdata_i = '0;
        #2;
        chk("rst_uc_ready", uc_write_ready_o, 1);
        chk("rst_full", wbuf_full_o, 0);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_uop", uop_ready_o, 0);
        chk("rst_rdy", read_ready_o, 0);
        chk("rst_we", data_we_o, 0);
        chk("rst_tag_we", tag_we_o, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Four hit stores with the bus stalled fill the buffer
        hit_write_i = 1; addr_i = 32'h100; wsel_i = 2'b01; wstrb_i = 4'hF; wdata_i = 32'h1111_0000;
        #1;
        chk("hit0_we", data_we_o, 8'h0F);
        chk("hit0_waddr", data_waddr_o, 10'h040);
        chk("hit0_wdata", data_wdata_o, 32'h1111_0000);
        cyc();
        addr_i = 32'h104; wsel_i = 2'b10; wdata_i = 32'h2222_0001;
        #1;
        chk("hit1_we", data_we_o, 8'hF0);
        chk("hit1_waddr", data_waddr_o, 10'h041);
        chk("hit1_head", bus_addr_o, 32'h100);
        cyc();
        addr_i = 32'h108; wsel_i = 2'b01; wdata_i = 32'h3333_0002;
        cyc();
        addr_i = 32'h10C; wstrb_i = 4'h3; wdata_i = 32'h4444_0003;
        #1;
        chk("three_not_full", wbuf_full_o, 0);
        cyc();
        hit_write_i = 0;
        #1;
        chk("full", wbuf_full_o, 1);
        chk("full_uc_ready", uc_write_ready_o, 0);
        chk("head_req", bus_req_o, 1);
        chk("head_we", bus_we_o, 1);
        chk("head_addr", bus_addr_o, 32'h100);
        chk("head_len", bus_len_o, 0);
        chk("head_wdata", bus_wdata_o, 32'h1111_0000);
        bus_ready_i = 1;
        cyc();
        bus_ready_i = 0;
        #1;
        chk("deq_full", wbuf_full_o, 0);
        chk("deq_uc_ready", uc_write_ready_o, 1);
        chk("deq_head", bus_addr_o, 32'h104);
        chk("deq_head_wdata", bus_wdata_o, 32'h2222_0001);

        // Enqueue and dequeue together keeps three entries; one more then fills it
        bus_ready_i = 1; uc_write_i = 1; addr_i = 32'h400; size_i = 2'd0; wstrb_i = 4'h1; wdata_i = 32'hAB;
        cyc();
        bus_ready_i = 0; uc_write_i = 0;
        #1;
        chk("simul_not_full", wbuf_full_o, 0);
        chk("simul_head", bus_addr_o, 32'h108);
        uc_write_i = 1; addr_i = 32'h404; size_i = 2'd2; wstrb_i = 4'hF; wdata_i = 32'hCD;
        cyc();
        uc_write_i = 0;
        #1;
        chk("refill_full", wbuf_full_o, 1);
        bus_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain%0d_addr", i), bus_addr_o, {32'h0, drain_addr[i]});
            cyc();
        end
        bus_ready_i = 0;
        #1;
        chk("drained_req", bus_req_o, 0);
        chk("drained_uc_size", 1'b0, 1'b0 ^ bus_req_o);

        // Miss store enqueues and completes immediately; then an uncached store
        miss_write_i = 1; addr_i = 32'h200; size_i = 2'd2; wstrb_i = 4'hF; wdata_i = 32'h5555_AAAA;
        #1;
        chk("miss_uop", uop_ready_o, 1);
        chk("miss_no_ram", data_we_o, 0);
        cyc();
        miss_write_i = 0;
        uc_write_i = 1; addr_i = 32'h300; wdata_i = 32'h66;
        #1;
        chk("miss_uop_gone", uop_ready_o, 0);
        cyc();
        uc_write_i = 0;

        // Uncached read waits for both buffered stores
        uc_read_req_i = 1; addr_i = 32'hBFD0_0000; size_i = 2'd2;
        #1;
        chk("ucr_w0_we", bus_we_o, 1);
        chk("ucr_w0_addr", bus_addr_o, 32'h200);
        cyc();
        bus_ready_i = 1;
        #1;
        chk("ucr_drain_w0", bus_addr_o, 32'h200);
        cyc();
        #1;
        chk("ucr_drain_w1_we", bus_we_o, 1);
        chk("ucr_drain_w1", bus_addr_o, 32'h300);
        cyc();
        bus_ready_i = 0;
        #1;
        chk("ucr_drain_idle", bus_req_o, 0);
        cyc();
        #1;
        chk("ucr_req", bus_req_o, 1);
        chk("ucr_we", bus_we_o, 0);
        chk("ucr_addr", bus_addr_o, 32'hBFD0_0000);
        chk("ucr_len", bus_len_o, 0);
        bus_ready_i = 1;
        cyc();
        bus_ready_i = 0; bus_rvalid_i = 1; bus_rlast_i = 1; bus_rdata_i = 32'h1234_5678;
        #1;
        chk("ucr_ready", read_ready_o, 1);
        chk("ucr_rdata", rdata_o, 32'h1234_5678);
        cyc();
        uc_read_req_i = 0; bus_rvalid_i = 0; bus_rlast_i = 0;
        #1;
        chk("ucr_ready_gone", read_ready_o, 0);

        // Refill at 0x8000_1234 into way 0
        refill_req_i = 1; addr_i = 32'h8000_1234;
        cyc();
        cyc();
        #1;
        chk("rf_req", bus_req_o, 1);
        chk("rf_we", bus_we_o, 0);
        chk("rf_addr", bus_addr_o, 32'h8000_1230);
        chk("rf_len", bus_len_o, 3);
        chk("rf_size", bus_size_o, 2);
        bus_ready_i = 1;
        cyc();
        bus_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            bus_rvalid_i = 1; bus_rdata_i = beat_a[k]; bus_rlast_i = (k == 3);
            #1;
            chk($sformatf("rf_beat%0d_waddr", k), data_waddr_o, 64'h08C + 64'(k));
            chk($sformatf("rf_beat%0d_we", k), data_we_o, 8'h0F);
            chk($sformatf("rf_beat%0d_wdata", k), data_wdata_o, {32'h0, beat_a[k]});
            cyc();
        end
        bus_rvalid_i = 0; bus_rlast_i = 0;
        #1;
        chk("rf_tag_we", tag_we_o, 2'b01);
        chk("rf_tag_waddr", tag_waddr_o, 8'h23);
        chk("rf_tag_wdata", tag_wdata_o, 21'h18_0001);
        chk("rf_uop", uop_ready_o, 1);
        chk("rf_rdy", read_ready_o, 1);
        chk("rf_rdata", rdata_o, 32'hA111_1111);
        cyc();
        refill_req_i = 0;
        #1;
        chk("rf_uop_gone", uop_ready_o, 0);

        // Invalidate
        inv_req_i = 1; addr_i = 32'h0000_0FF0;
        cyc();
        #1;
        chk("inv_waddr", tag_waddr_o, 8'hFF);
        chk("inv_we", tag_we_o, 2'b11);
        chk("inv_wdata", tag_wdata_o, 0);
        chk("inv_uop", uop_ready_o, 1);
        inv_req_i = 0;
        cyc();
        #1;
        chk("inv_uop_gone", uop_ready_o, 0);
        chk("inv_we_gone", tag_we_o, 0);

        // Second refill uses way 1 and wraps the victim counter
        refill_req_i = 1; addr_i = 32'h0000_0040;
        cyc();
        cyc();
        bus_ready_i = 1;
        cyc();
        bus_ready_i = 0;
        bus_rvalid_i = 1; bus_rdata_i = 32'hB0B0_B0B0;
        #1;
        chk("rf2_we", data_we_o, 8'hF0);
        chk("rf2_waddr", data_waddr_o, 10'h010);
        cyc();
        for (int k = 1; k < 4; k++) begin
            bus_rdata_i = 32'hB000_0000 + 32'(k); bus_rlast_i = (k == 3);
            cyc();
        end
        bus_rvalid_i = 0; bus_rlast_i = 0;
        #1;
        chk("rf2_tag_we", tag_we_o, 2'b10);
        chk("rf2_tag_wdata", tag_wdata_o, 21'h10_0000);
        chk("rf2_rdata", rdata_o, 32'hB0B0_B0B0);
        cyc();
        refill_req_i = 0;

        // Reset during refill beat 2
        refill_req_i = 1; addr_i = 32'h8000_1234;
        cyc();
        cyc();
        bus_ready_i = 1;
        cyc();
        bus_ready_i = 0;
        bus_rvalid_i = 1; bus_rdata_i = beat_a[0];
        #1;
        chk("rst_rf_wrap_we", data_we_o, 8'h0F);
        cyc();
        bus_rdata_i = beat_a[1];
        cyc();
        bus_rdata_i = beat_a[2];
        rst_n = 1'b0;
        #1;
        chk("midrst_bus_req", bus_req_o, 0);
        chk("midrst_we", data_we_o, 0);
        chk("midrst_uc_ready", uc_write_ready_o, 1);
        bus_rvalid_i = 0; refill_req_i = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        bus_rvalid_i = 1; bus_rdata_i = beat_a[3];
        #1;
        chk("postrst_we", data_we_o, 0);
        chk("postrst_req", bus_req_o, 0);
        chk("postrst_uop", uop_ready_o, 0);
        bus_rvalid_i = 0;
        cyc();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
